// File: rtl/xor_nn_seq_if.sv
// Host-side bus of the XOR self-test sequencer: weight-write port, run control
// and the per-vector result stream.
interface xor_nn_seq_if #(
    parameter int WIDTH = 16
);
    logic                    cfg_we;
    logic [3:0]              cfg_addr;
    logic signed [WIDTH-1:0] cfg_wdata;
    logic                    cfg_err;
    logic                    start;
    logic                    busy;
    logic                    out_valid;
    logic [1:0]              out_idx;
    logic signed [WIDTH-1:0] out_value;
    logic                    out_ok;
    logic                    done;
    logic                    pass;
    logic [3:0]              fail_mask;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start,
        input  cfg_err, busy, out_valid, out_idx, out_value, out_ok, done, pass, fail_mask
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start,
        output cfg_err, busy, out_valid, out_idx, out_value, out_ok, done, pass, fail_mask
    );
endinterface

// File: rtl/xor_nn_seq.sv
// Weight register file and XOR self-test sequencer for the relu_nn 2-2-1 core:
// drives the four XOR vectors, samples the core output and grades each result.
module xor_nn_seq #(
    parameter int                      WIDTH  = 16,
    parameter int                      FRAC   = 8,
    parameter int                      HOLD   = 8,
    parameter logic signed [WIDTH-1:0] THRESH = 16'sh0080
) (
    input  logic                    clk,
    input  logic                    rst,
    xor_nn_seq_if.slave             bus,
    output logic signed [WIDTH-1:0] h1_w1,
    output logic signed [WIDTH-1:0] h1_w2,
    output logic signed [WIDTH-1:0] h1_bias,
    output logic signed [WIDTH-1:0] h2_w1,
    output logic signed [WIDTH-1:0] h2_w2,
    output logic signed [WIDTH-1:0] h2_bias,
    output logic signed [WIDTH-1:0] out_w1,
    output logic signed [WIDTH-1:0] out_w2,
    output logic signed [WIDTH-1:0] out_bias,
    output logic signed [WIDTH-1:0] net_input1,
    output logic signed [WIDTH-1:0] net_input2,
    input  logic signed [WIDTH-1:0] net_output
);
    localparam int                      CNT_W    = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic signed [WIDTH-1:0] ONE      = WIDTH'(1 << FRAC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_n;
    logic [1:0]              vec, vec_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic signed [WIDTH-1:0] in1_n, in2_n, value_n;
    logic                    busy_n, valid_n, ok_n, done_n, pass_n, sample_ok;
    logic [1:0]              idx_n;
    logic [3:0]              mask_n, mask_upd;
    logic signed [WIDTH-1:0] regs [9];

    // Vector v = {in1, in2} as bits: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1).
    function automatic logic signed [WIDTH-1:0] vec_in1(input logic [1:0] v);
        return v[1] ? ONE : '0;
    endfunction

    function automatic logic signed [WIDTH-1:0] vec_in2(input logic [1:0] v);
        return v[0] ? ONE : '0;
    endfunction

    function automatic logic expect_one(input logic [1:0] v);
        return v[0] ^ v[1];
    endfunction

    // A value exactly at the threshold is wrong for either expectation.
    function automatic logic result_ok(input logic signed [WIDTH-1:0] val, input logic want);
        return want ? (val > THRESH) : (val < THRESH);
    endfunction

    assign sample_ok = result_ok(net_output, expect_one(vec));

    always_comb begin
        mask_upd      = bus.fail_mask;
        mask_upd[vec] = !sample_ok;
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        cnt_n   = cnt;
        in1_n   = net_input1;
        in2_n   = net_input2;
        busy_n  = bus.busy;
        valid_n = 1'b0;
        idx_n   = bus.out_idx;
        value_n = bus.out_value;
        ok_n    = bus.out_ok;
        done_n  = 1'b0;
        pass_n  = bus.pass;
        mask_n  = bus.fail_mask;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    vec_n   = 2'd0;
                    cnt_n   = '0;
                    in1_n   = vec_in1(2'd0);
                    in2_n   = vec_in2(2'd0);
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    mask_n  = 4'd0;
                end
            end
            RUN: begin
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    valid_n = 1'b1;
                    idx_n   = vec;
                    value_n = net_output;
                    ok_n    = sample_ok;
                    mask_n  = mask_upd;
                    if (vec != 2'd3) begin
                        vec_n = vec + 2'd1;
                        cnt_n = '0;
                        in1_n = vec_in1(vec + 2'd1);
                        in2_n = vec_in2(vec + 2'd1);
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (mask_upd == 4'd0);
                        in1_n   = '0;
                        in2_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= '0;
            cnt           <= '0;
            net_input1    <= '0;
            net_input2    <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_idx   <= '0;
            bus.out_value <= '0;
            bus.out_ok    <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail_mask <= '0;
        end else begin
            state         <= state_n;
            vec           <= vec_n;
            cnt           <= cnt_n;
            net_input1    <= in1_n;
            net_input2    <= in2_n;
            bus.busy      <= busy_n;
            bus.out_valid <= valid_n;
            bus.out_idx   <= idx_n;
            bus.out_value <= value_n;
            bus.out_ok    <= ok_n;
            bus.done      <= done_n;
            bus.pass      <= pass_n;
            bus.fail_mask <= mask_n;
        end
    end

    // Weights only change from IDLE, so the core sees a frozen set for a whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cfg_err <= 1'b0;
            for (int i = 0; i < 9; i++) regs[i] <= '0;
        end else begin
            bus.cfg_err <= 1'b0;
            if (bus.cfg_we) begin
                if (state == RUN || bus.cfg_addr > 4'd8) begin
                    bus.cfg_err <= 1'b1;
                end else begin
                    for (int i = 0; i < 9; i++) begin
                        if (bus.cfg_addr == 4'(i)) regs[i] <= bus.cfg_wdata;
                    end
                end
            end
        end
    end

    assign h1_w1    = regs[0];
    assign h1_w2    = regs[1];
    assign h1_bias  = regs[2];
    assign h2_w1    = regs[3];
    assign h2_w2    = regs[4];
    assign h2_bias  = regs[5];
    assign out_w1   = regs[6];
    assign out_w2   = regs[7];
    assign out_bias = regs[8];
endmodule
